multicycle_decode: RTL

Parametrised multicycle control unit: the successor to the single-cycle main/ALU decoder, driving a shared-memory, single-ALU datapath over several cycles per instruction. Holds a Moore FSM (fetch, decode, memory, execute, multiply, writeback, branch), a multiply-latency counter, a latched byte-access qualifier and the ALU decoder. It sits between the instruction register and the datapath; the condition-check stage gates its RegW/MemW/Branch/NextPC.

---
 rtl/multicycle_decode.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_decode.sv
// Multicycle control unit: Moore sequencing FSM, multiply-latency counter,
// latched byte-access qualifier and ALU decoder for a shared-memory datapath.
//
// state  | meaning
// FETCH  | read instruction, PC += 4
// DECODE | read registers, classify instruction
// MEMADR | compute load/store address
// MEMRD  | read data memory
// MEMWB  | write loaded data to register file
// MEMWR  | write data memory
// EXECR  | ALU op, register operand
// EXECI  | ALU op, immediate operand
// MULX   | multiply, held MUL_CYCLES cycles
// ALUWB  | write ALU result to register file
// BRANCH | compute branch target
module multicycle_decode #(
    parameter int ALUCTRL_W  = 4,
    parameter int MUL_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    output logic                 IRWrite,
    output logic                 NextPC,
    output logic                 AdrSrc,
    output logic                 RegW,
    output logic                 MemW,
    output logic                 Branch,
    output logic                 ALUOp,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [1:0]           FlagW,
    output logic                 PCS,
    output logic                 Byte,
    output logic                 Illegal,
    output logic [3:0]           State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        MULX   = 4'd8,
        ALUWB  = 4'd9,
        BRANCH = 4'd10
    } state_t;

    localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

    state_t     state;
    state_t     state_nx;
    logic [3:0] mul_cnt;
    logic       byte_q;

    logic       cmd_known;
    logic       cmd_mul;
    logic       cmd_arith;
    logic [3:0] alu_code;

    always_comb begin
        cmd_known = 1'b1;
        cmd_mul   = 1'b0;
        cmd_arith = 1'b0;
        alu_code  = 4'd0;
        case (Funct[4:1])
            4'b0100: begin alu_code = 4'd0;  cmd_arith = 1'b1; end
            4'b0010: begin alu_code = 4'd1;  cmd_arith = 1'b1; end
            4'b1101: begin alu_code = 4'd2;  cmd_arith = 1'b1; end
            4'b0000: alu_code = 4'd3;
            4'b1100: alu_code = 4'd4;
            4'b1011: begin alu_code = 4'd5;  cmd_mul = 1'b1; end
            4'b1001: begin alu_code = 4'd6;  cmd_mul = 1'b1; end
            4'b1010: begin alu_code = 4'd7;  cmd_mul = 1'b1; end
            4'b0011: begin alu_code = 4'd8;  cmd_arith = 1'b1; end
            4'b0111: begin alu_code = 4'd9;  cmd_arith = 1'b1; end
            4'b0101: begin alu_code = 4'd10; cmd_arith = 1'b1; end
            default: cmd_known = 1'b0;
        endcase
    end

    // Unknown data-processing commands abort to FETCH ahead of the EXECI/EXECR split.
    always_comb begin
        state_nx = FETCH;
        case (state)
            FETCH:  state_nx = DECODE;
            DECODE: begin
                case (Op)
                    2'b00: begin
                        if (!cmd_known)
                            state_nx = FETCH;
                        else if (Funct[5])
                            state_nx = EXECI;
                        else if (cmd_mul)
                            state_nx = MULX;
                        else
                            state_nx = EXECR;
                    end
                    2'b01:   state_nx = MEMADR;
                    2'b10:   state_nx = BRANCH;
                    default: state_nx = FETCH;
                endcase
            end
            MEMADR: state_nx = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_nx = MEMWB;
            EXECR:  state_nx = ALUWB;
            EXECI:  state_nx = ALUWB;
            MULX:   state_nx = (mul_cnt == MUL_LAST) ? ALUWB : MULX;
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            mul_cnt <= 4'd0;
            byte_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == MULX && state_nx == MULX)
                mul_cnt <= mul_cnt + 4'd1;
            else
                mul_cnt <= 4'd0;
            if (state_nx == FETCH)
                byte_q <= 1'b0;
            else if (state == DECODE)
                byte_q <= (Op == 2'b01) & Funct[2];
        end
    end

    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        AdrSrc    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        case (state)
            FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECR:  ALUOp = 1'b1;
            MULX:   ALUOp = 1'b1;
            EXECI: begin
                ALUOp   = 1'b1;
                ALUSrcB = 2'b01;
            end
            ALUWB:  RegW = 1'b1;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            default: ;
        endcase
    end

    assign ALUControl = !ALUOp    ? '0 :
                        cmd_known ? ALUCTRL_W'(alu_code) : '1;
    assign FlagW      = ALUOp ? {Funct[0], Funct[0] & cmd_arith} : 2'b00;
    assign PCS        = Branch | (RegW & (Rd == 4'hF));
    assign Illegal    = (state == DECODE) &&
                        ((Op == 2'b11) || ((Op == 2'b00) && !cmd_known));
    assign Byte       = byte_q;
    assign State      = state;

endmodule
